// File: rtl/vga_fml_arbiter.sv
// vga_fml_arbiter: shares the single VGA FML read channel among the text,
// planar and linear fetch engines.
//
// Build option:
//   VGA_FML_ARB_RR_EN  defined   -> round-robin arbitration, 2-bit last-winner pointer
//                      undefined -> fixed priority m0 > m1 > m2, no pointer register
//
// Handshake: a requester raises mN_stb_i with mN_adr_i. Once granted, its
// strobe is no longer looked at. The arbiter raises fml_stb_o until the
// fml_ack_i cycle. That cycle and the next BURST_LEN-1 cycles carry read
// data, and mN_dv_o flags them to the granted port.
//
// dbg_state exposes the FSM state: 0 = IDLE, 1 = REQ, 2 = BURST.

module vga_fml_arbiter #(
    parameter int BURST_LEN = 8
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        m0_stb_i,
    input  logic [17:1] m0_adr_i,
    output logic        m0_ack_o,
    output logic        m0_dv_o,

    input  logic        m1_stb_i,
    input  logic [17:1] m1_adr_i,
    output logic        m1_ack_o,
    output logic        m1_dv_o,

    input  logic        m2_stb_i,
    input  logic [17:1] m2_adr_i,
    output logic        m2_ack_o,
    output logic        m2_dv_o,

    output logic [15:0] m_dat_o,

    output logic [17:1] fml_adr_o,
    output logic        fml_stb_o,
    output logic        fml_we_o,
    input  logic        fml_ack_i,
    input  logic [15:0] fml_dat_i,

    output logic [1:0]  dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_REQ   = 2'd1,
        S_BURST = 2'd2
    } state_t;

    // Beats still to come after the ack beat, minus one (the counter ends at 0).
    localparam logic [3:0] BEAT_LOAD = 4'(BURST_LEN - 2);

    state_t      state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic [3:0]  beat_cnt_q, beat_cnt_d;
    logic [17:1] adr_q, adr_d;

    logic [2:0]  req;
    logic        win_vld;
    logic [1:0]  win;
    logic [17:1] win_adr;

    assign req     = {m2_stb_i, m1_stb_i, m0_stb_i};
    assign win_vld = |req;

`ifdef VGA_FML_ARB_RR_EN
    logic [1:0] rr_ptr_q, rr_ptr_d;

    // Round-robin winner: search starts just after the last winner.
    always_comb begin
        win = 2'd0;
        case (rr_ptr_q)
            2'd0: begin
                if (req[1])      win = 2'd1;
                else if (req[2]) win = 2'd2;
                else             win = 2'd0;
            end
            2'd1: begin
                if (req[2])      win = 2'd2;
                else if (req[0]) win = 2'd0;
                else             win = 2'd1;
            end
            default: begin
                if (req[0])      win = 2'd0;
                else if (req[1]) win = 2'd1;
                else             win = 2'd2;
            end
        endcase
    end

    // The pointer follows every grant made in IDLE.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (state_q == S_IDLE && win_vld) rr_ptr_d = win;
    end

    // Pointer register.
    always_ff @(posedge clk) begin
        if (rst) rr_ptr_q <= 2'd0;
        else     rr_ptr_q <= rr_ptr_d;
    end
`else
    // Fixed-priority winner: m0 beats m1, and m1 beats m2.
    always_comb begin
        win = 2'd0;
        if (req[0])      win = 2'd0;
        else if (req[1]) win = 2'd1;
        else if (req[2]) win = 2'd2;
    end
`endif

    // Address of the winning requester.
    always_comb begin
        win_adr = m0_adr_i;
        case (win)
            2'd0:    win_adr = m0_adr_i;
            2'd1:    win_adr = m1_adr_i;
            default: win_adr = m2_adr_i;
        endcase
    end

    // Next-state logic. The burst address and grant are latched only in IDLE.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        beat_cnt_d = beat_cnt_q;
        adr_d      = adr_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    adr_d   = win_adr;
                    grant_d = win;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (fml_ack_i) begin
                    beat_cnt_d = BEAT_LOAD;
                    state_d    = S_BURST;
                end
            end
            S_BURST: begin
                if (beat_cnt_q == 4'd0) state_d = S_IDLE;
                else                    beat_cnt_d = beat_cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State, grant, beat counter and address registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= 2'd0;
            beat_cnt_q <= 4'd0;
            adr_q      <= '0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            beat_cnt_q <= beat_cnt_d;
            adr_q      <= adr_d;
        end
    end

    logic ack_ev, dv_ev;
    assign ack_ev = (state_q == S_REQ) && fml_ack_i;
    assign dv_ev  = ack_ev || (state_q == S_BURST);

    assign m0_ack_o = ack_ev && (grant_q == 2'd0);
    assign m1_ack_o = ack_ev && (grant_q == 2'd1);
    assign m2_ack_o = ack_ev && (grant_q == 2'd2);
    assign m0_dv_o  = dv_ev  && (grant_q == 2'd0);
    assign m1_dv_o  = dv_ev  && (grant_q == 2'd1);
    assign m2_dv_o  = dv_ev  && (grant_q == 2'd2);

    assign m_dat_o   = fml_dat_i;
    assign fml_adr_o = adr_q;
    assign fml_stb_o = (state_q == S_REQ);
    assign fml_we_o  = 1'b0;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_vga_fml_arbiter.sv
// Directed testbench for vga_fml_arbiter. The main instance uses BURST_LEN=8.
// Two extra instances (BURST_LEN=2 and 16) share the same inputs and are
// checked in the final burst-length sweep.

module tb_vga_fml_arbiter;

    localparam int BL = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        m0_stb = 1'b0, m1_stb = 1'b0, m2_stb = 1'b0;
    logic [16:0] m0_adr = '0, m1_adr = '0, m2_adr = '0;
    logic        fml_ack = 1'b0;
    logic [15:0] fml_dat = '0;

    logic [2:0]  ack8, dv8, ack2, dv2, ack16, dv16;
    logic [15:0] mdat8, mdat2, mdat16;
    logic [16:0] adr8, adr2, adr16;
    logic        stb8, stb2, stb16, we8, we2, we16;
    logic [1:0]  st8, st2, st16;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    vga_fml_arbiter #(.BURST_LEN(8)) u_dut (
        .clk(clk), .rst(rst),
        .m0_stb_i(m0_stb), .m0_adr_i(m0_adr), .m0_ack_o(ack8[0]), .m0_dv_o(dv8[0]),
        .m1_stb_i(m1_stb), .m1_adr_i(m1_adr), .m1_ack_o(ack8[1]), .m1_dv_o(dv8[1]),
        .m2_stb_i(m2_stb), .m2_adr_i(m2_adr), .m2_ack_o(ack8[2]), .m2_dv_o(dv8[2]),
        .m_dat_o(mdat8), .fml_adr_o(adr8), .fml_stb_o(stb8), .fml_we_o(we8),
        .fml_ack_i(fml_ack), .fml_dat_i(fml_dat), .dbg_state(st8)
    );

    vga_fml_arbiter #(.BURST_LEN(2)) u_b2 (
        .clk(clk), .rst(rst),
        .m0_stb_i(m0_stb), .m0_adr_i(m0_adr), .m0_ack_o(ack2[0]), .m0_dv_o(dv2[0]),
        .m1_stb_i(m1_stb), .m1_adr_i(m1_adr), .m1_ack_o(ack2[1]), .m1_dv_o(dv2[1]),
        .m2_stb_i(m2_stb), .m2_adr_i(m2_adr), .m2_ack_o(ack2[2]), .m2_dv_o(dv2[2]),
        .m_dat_o(mdat2), .fml_adr_o(adr2), .fml_stb_o(stb2), .fml_we_o(we2),
        .fml_ack_i(fml_ack), .fml_dat_i(fml_dat), .dbg_state(st2)
    );

    vga_fml_arbiter #(.BURST_LEN(16)) u_b16 (
        .clk(clk), .rst(rst),
        .m0_stb_i(m0_stb), .m0_adr_i(m0_adr), .m0_ack_o(ack16[0]), .m0_dv_o(dv16[0]),
        .m1_stb_i(m1_stb), .m1_adr_i(m1_adr), .m1_ack_o(ack16[1]), .m1_dv_o(dv16[1]),
        .m2_stb_i(m2_stb), .m2_adr_i(m2_adr), .m2_ack_o(ack16[2]), .m2_dv_o(dv16[2]),
        .m_dat_o(mdat16), .fml_adr_o(adr16), .fml_stb_o(stb16), .fml_we_o(we16),
        .fml_ack_i(fml_ack), .fml_dat_i(fml_dat), .dbg_state(st16)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled on the falling edge.
    task automatic go();
        @(posedge clk);
        #1;
    endtask

    task automatic samp();
        @(negedge clk);
    endtask

    // Serve one burst of the main instance, starting from an IDLE cycle in
    // which port g's request is pending. The ack arrives lat cycles after
    // the strobe rises. If late is set, m0 drops its request and m2 raises
    // one during the ack cycle.
    task automatic serve(input int g, input logic [16:0] adr, input int lat,
                         input logic [15:0] d0, input logic [15:0] dbase, input bit late);
        logic [2:0] oh;
        oh = 3'(1 << g);
        go();
        samp();
        chk("req_state", 32'(st8), 32'd1);
        chk("req_stb", 32'(stb8), 32'd1);
        chk("req_adr", 32'(adr8), 32'(adr));
        for (int i = 0; i < lat; i++) begin
            chk("wait_ack", 32'(ack8), 32'd0);
            chk("wait_dv", 32'(dv8), 32'd0);
            go();
            samp();
            chk("wait_stb", 32'(stb8), 32'd1);
            chk("wait_adr", 32'(adr8), 32'(adr));
        end
        fml_ack = 1'b1;
        fml_dat = d0;
        if (late) begin
            m0_stb = 1'b0;
            m2_stb = 1'b1;
            m2_adr = 17'h0AAAA;
        end
        #1;
        chk("ack_pulse", 32'(ack8), 32'(oh));
        chk("ack_dv", 32'(dv8), 32'(oh));
        chk("ack_dat", 32'(mdat8), 32'(d0));
        go();
        fml_ack = 1'b0;
        for (int k = 0; k < BL - 1; k++) begin
            if (k != 0) go();
            fml_dat = dbase - 16'(k);
            samp();
            chk("beat_dv", 32'(dv8), 32'(oh));
            chk("beat_ack", 32'(ack8), 32'd0);
            chk("beat_stb", 32'(stb8), 32'd0);
            chk("beat_state", 32'(st8), 32'd2);
            chk("beat_dat", 32'(mdat8), 32'(dbase - 16'(k)));
        end
        go();
        samp();
        chk("end_dv", 32'(dv8), 32'd0);
        chk("end_state", 32'(st8), 32'd0);
        chk("end_stb", 32'(stb8), 32'd0);
    endtask

    initial begin
        int n8, n2, n16;

        // Reset state.
        go();
        go();
        samp();
        chk("rst_state", 32'(st8), 32'd0);
        chk("rst_stb", 32'(stb8), 32'd0);
        chk("rst_adr", 32'(adr8), 32'd0);
        chk("rst_we", 32'(we8), 32'd0);
        chk("rst_ack", 32'(ack8), 32'd0);
        chk("rst_dv", 32'(dv8), 32'd0);
        rst = 1'b0;

        // Single burst from m1 with a 3-cycle ack latency.
        m1_stb = 1'b1;
        m1_adr = 17'h00A40;
        serve(1, 17'h00A40, 3, 16'hBEEF, 16'hEBA7, 1'b0);
        m1_stb = 1'b0;

        // Contention, starting from a freshly reset pointer.
        rst = 1'b1;
        go();
        rst = 1'b0;
        samp();
        m0_stb = 1'b1; m0_adr = 17'h00100;
        m1_stb = 1'b1; m1_adr = 17'h00200;
        m2_stb = 1'b1; m2_adr = 17'h00300;
`ifdef VGA_FML_ARB_RR_EN
        serve(1, 17'h00200, 0, 16'h0001, 16'h0010, 1'b0);
        serve(2, 17'h00300, 0, 16'h0002, 16'h0020, 1'b0);
        serve(0, 17'h00100, 0, 16'h0003, 16'h0030, 1'b0);
        serve(1, 17'h00200, 0, 16'h0004, 16'h0040, 1'b0);
`else
        serve(0, 17'h00100, 0, 16'h0001, 16'h0010, 1'b0);
        serve(0, 17'h00100, 0, 16'h0002, 16'h0020, 1'b0);
        m0_stb = 1'b0;
        serve(1, 17'h00200, 0, 16'h0003, 16'h0030, 1'b0);
        m1_stb = 1'b0;
        serve(2, 17'h00300, 0, 16'h0004, 16'h0040, 1'b0);
`endif
        m0_stb = 1'b0; m1_stb = 1'b0; m2_stb = 1'b0;
        go();
        samp();
        chk("idle_hold", 32'(st8), 32'd0);

        // Late request: m2 raises stb during m0's burst and m0 drops its request after the grant.
        m0_stb = 1'b1;
        m0_adr = 17'h1F000;
        serve(0, 17'h1F000, 1, 16'h1111, 16'h2222, 1'b1);
        serve(2, 17'h0AAAA, 0, 16'h3333, 16'h4444, 1'b0);
        m2_stb = 1'b0;

        // Stalled ack: the strobe and address hold for 50 cycles.
        m1_stb = 1'b1;
        m1_adr = 17'h15555;
        serve(1, 17'h15555, 50, 16'h5555, 16'h6666, 1'b0);
        m1_stb = 1'b0;

        // Reset at beat 4 of an m0 burst.
        m0_stb = 1'b1;
        m0_adr = 17'h12345;
        go();
        m0_stb = 1'b0;
        samp();
        chk("mrst_req", 32'(st8), 32'd1);
        fml_ack = 1'b1;
        #1;
        chk("mrst_ack", 32'(ack8), 32'd1);
        go();
        fml_ack = 1'b0;
        go();
        go();
        rst = 1'b1;
        samp();
        chk("mrst_beat4", 32'(dv8), 32'd1);
        go();
        rst = 1'b0;
        samp();
        chk("mrst_dv", 32'(dv8), 32'd0);
        chk("mrst_stb", 32'(stb8), 32'd0);
        chk("mrst_state", 32'(st8), 32'd0);
        chk("mrst_adr", 32'(adr8), 32'd0);
        for (int i = 0; i < 3; i++) begin
            go();
            samp();
            chk("mrst_quiet", 32'(dv8), 32'd0);
        end
        m0_stb = 1'b1;
        m0_adr = 17'h00321;
        serve(0, 17'h00321, 2, 16'h7777, 16'h8888, 1'b0);
        m0_stb = 1'b0;

        // Burst-length sweep: all three instances see the same single request.
        rst = 1'b1;
        go();
        go();
        rst = 1'b0;
        m0_stb = 1'b1;
        m0_adr = 17'h00005;
        go();
        m0_stb = 1'b0;
        samp();
        fml_ack = 1'b1;
        #1;
        n8 = 32'(dv8[0]);
        n2 = 32'(dv2[0]);
        n16 = 32'(dv16[0]);
        go();
        fml_ack = 1'b0;
        samp();
        chk("b16_load", 32'(u_b16.beat_cnt_q), 32'd14);
        n8 += 32'(dv8[0]);
        n2 += 32'(dv2[0]);
        n16 += 32'(dv16[0]);
        for (int i = 0; i < 20; i++) begin
            go();
            samp();
            n8 += 32'(dv8[0]);
            n2 += 32'(dv2[0]);
            n16 += 32'(dv16[0]);
        end
        chk("sweep_bl8", 32'(n8), 32'd8);
        chk("sweep_bl2", 32'(n2), 32'd2);
        chk("sweep_bl16", 32'(n16), 32'd16);
        chk("sweep_idle16", 32'(st16), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_fml_arbiter.md
# vga_fml_arbiter

Three-port read arbiter that shares the single VGA FML read channel among the text-mode, planar and linear fetch engines. It latches one requester's burst address, drives the FML strobe until acknowledge, then tracks the fixed-length read burst and routes ack/data-valid back to the winning requester. It sits between the mode fetchers and the FML memory port, in the same clock domain as the CRTC/sequencer.

## Interface

Parameters:
- `BURST_LEN`, 8: data beats per FML read burst, including the ack beat. Legal range 2..16.

Ports:
- `clk`  in  1: system clock; all logic is rising-edge.
- `rst`  in  1: synchronous, active-high reset.
- `m0_stb_i` / `m1_stb_i` / `m2_stb_i`  in  1: read request from text / planar / linear fetcher.
- `m0_adr_i` / `m1_adr_i` / `m2_adr_i`  in  17 ([17:1]): word address of the requested burst.
- `m0_ack_o` / `m1_ack_o` / `m2_ack_o`  out  1: one-cycle pulse to the granted port when FML acknowledges.
- `m0_dv_o` / `m1_dv_o` / `m2_dv_o`  out  1: `fml_dat_i` is valid for this port this cycle.
- `m_dat_o`  out  16: `fml_dat_i`, broadcast to all ports.
- `fml_adr_o`  out  17 ([17:1]): latched burst address.
- `fml_stb_o`  out  1: FML request strobe.
- `fml_we_o`  out  1: tied 0 (read-only channel).
- `fml_ack_i`  in  1: FML acknowledge; the first data beat arrives in the same cycle.
- `fml_dat_i`  in  16: FML read data.

## Operation

State machine with three states: IDLE, REQ, BURST.

**IDLE**
- If any `mN_stb_i` is high, select a winner per the arbitration policy (see Configuration).
- Register `fml_adr_o <= mN_adr_i` and `grant <= N`, then go to REQ.
- Otherwise stay in IDLE.

**REQ**
- `fml_stb_o = 1`, decoded from the registered state.
- On `fml_ack_i`:
  - `m<grant>_ack_o = 1` and `m<grant>_dv_o = 1` (combinational).
  - Load `beat_cnt <= BURST_LEN-2`; go to BURST.
- No timeout: REQ waits for ack indefinitely.
- The granted requester's `stb` is not re-sampled after grant. A request dropped after grant is still served, and its data is flagged to that port.

**BURST**
- `m<grant>_dv_o = 1` every cycle.
- Decrement `beat_cnt`; when it is 0, go to IDLE.
- `beat_cnt` is a 4-bit counter.
- `fml_ack_i` seen in BURST is ignored; it is a protocol violation.

**Common rules**
- Requests from non-granted ports arriving in REQ or BURST wait; they are evaluated in the next IDLE cycle.
- Simultaneous requests in IDLE resolve to exactly one grant; the losers keep `stb` high and are considered next IDLE.
- `m_dat_o` is pure wiring; no data buffering.

## Timing

- Reset values:
  - state = IDLE
  - `fml_stb_o` = 0, `fml_adr_o` = 0, `fml_we_o` = 0
  - all `mN_ack_o` and `mN_dv_o` = 0
  - `grant` = 0, `beat_cnt` = 0
  - round-robin pointer = 0
- Request-to-strobe latency: `stb_i` sampled high at edge T gives `fml_stb_o` high from T+1.
- Strobe deassert: `fml_stb_o` is low in the cycle after the ack cycle.
- `ack_o`/`dv_o` are combinational from `fml_ack_i`. The ack cycle and the following `BURST_LEN-1` cycles assert `dv`, giving exactly `BURST_LEN` dv cycles.
- Minimum burst-to-burst spacing: one IDLE cycle after the last beat. The back-to-back period is `BURST_LEN` + 1 + ack latency.
- `rst` asserted in any state, including mid-burst:
  - next cycle is IDLE with all outputs at reset values;
  - the remaining burst beats are not flagged to any port.

## Configuration

- `VGA_FML_ARB_RR_EN` defined: round-robin arbitration.
  - A 2-bit pointer records the last winner.
  - Search order starts at pointer+1, wrapping 2 → 0.
  - The pointer updates on each grant.
- Undefined: fixed priority, m0 > m1 > m2; no pointer register exists.

## Test plan

- **Single burst:** m1 requests at adr 0x00A40; FML acks 3 cycles after strobe with data 0xBEEF, then 0x1EBA7..0x1EBA1 (truncated to 16 bits) → `fml_adr_o` = 0x00A40; `m1_ack_o` pulses once; `m1_dv_o` high for 8 consecutive cycles; m0/m2 ack and dv stay 0; `fml_stb_o` low in the cycle after ack.
- **Contention:** m0, m1 and m2 all hold `stb` at once.
  - RR build: grants m1, m2, m0 (pointer starts at 0), then m1 again while all keep requesting.
  - Fixed build: m0 wins every time while it keeps requesting.
- **Late request:** m2 raises `stb` during an m0 burst → m2 is granted in the first IDLE cycle after m0's 8th dv beat; its `fml_stb_o` rises one cycle later.
- **Reset mid-burst:** `rst` pulsed at beat 4 → next cycle: all dv low, `fml_stb_o` low, state IDLE. A fresh m0 request then completes a full 8-beat burst.
- **Stalled ack:** hold `fml_ack_i` low for 50 cycles → `fml_stb_o` stays high and `fml_adr_o` stays stable for all 50 cycles; no ack or dv is asserted.
- **Parameter sweep:** `BURST_LEN` = 2 → exactly 2 dv cycles per burst. `BURST_LEN` = 16 → exactly 16 dv cycles per burst, with `beat_cnt` loaded with 14.
